// File: rtl/fuzz_vector_sequencer_if.sv
// Bundle of the sequencer's run handshake, vector ROM port, DUT stimulus/response
// buses and the signature outputs.
//   master : the sequencer (drives busy/done/vec_rd/vec_addr/dut_in/sig/vec_cnt)
//   slave  : the environment (drives start, ROM data vec_data, DUT output dut_y)
interface fuzz_vector_sequencer_if #(
    parameter int VEC_W  = 256,
    parameter int Y_W    = 635,
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              vec_rd;
    logic [ADDR_W-1:0] vec_addr;
    logic [VEC_W-1:0]  vec_data;
    logic [VEC_W-1:0]  dut_in;
    logic [Y_W-1:0]    dut_y;
    logic [31:0]       sig;
    logic [ADDR_W:0]   vec_cnt;

    modport master (
        input  start, vec_data, dut_y,
        output busy, done, vec_rd, vec_addr, dut_in, sig, vec_cnt
    );

    modport slave (
        output start, vec_data, dut_y,
        input  busy, done, vec_rd, vec_addr, dut_in, sig, vec_cnt
    );
endinterface

// File: rtl/fuzz_vector_sequencer.sv
// Steps through NUM_VEC stimulus vectors held in an external ROM: reads a vector,
// registers it onto dut_in, lets the DUT settle for SETTLE cycles, then folds the
// DUT output y into a 32-bit MISR signature. One run costs NUM_VEC*(3+SETTLE) cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears state, bus outputs and signature)
//   bus    master side of fuzz_vector_sequencer_if:
//            start (in) run request, accepted only when idle or done
//            busy/done (out) run status, both registered
//            vec_rd/vec_addr (out), vec_data (in) ROM port, data 1 cycle after vec_rd
//            dut_in (out) registered stimulus, dut_y (in) DUT response
//            sig (out) running MISR, vec_cnt (out) vectors captured this run
module fuzz_vector_sequencer #(
    parameter int VEC_W   = 256,
    parameter int Y_W     = 635,
    parameter int NUM_VEC = 21,
    parameter int ADDR_W  = 5,
    parameter int SETTLE  = 1
) (
    input  logic clk,
    input  logic rst_n,
    fuzz_vector_sequencer_if.master bus
);

    localparam int              NWORDS    = (Y_W + 31) / 32;
    localparam logic [31:0]     POLY      = 32'h0040_0007;   // x^32+x^22+x^2+x+1
    localparam logic [ADDR_W:0] NUM_VEC_C = (ADDR_W + 1)'(NUM_VEC);
    localparam logic [7:0]      SETTLE_C  = 8'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_t;

    state_t            state_q,  state_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              vec_rd_q, vec_rd_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [VEC_W-1:0]  dut_in_q, dut_in_d;
    logic [31:0]       sig_q,    sig_d;
    logic [ADDR_W:0]   cnt_q,    cnt_d;
    logic [7:0]        wait_q,   wait_d;
    logic [ADDR_W:0]   cnt_inc;

    // y is zero-extended to a whole number of 32-bit words, XOR-folded to one word,
    // and injected into a Galois-style shift of the current signature.
    function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [Y_W-1:0] y);
        logic [NWORDS*32-1:0] yp;
        logic [31:0]          fold;
        yp            = '0;
        yp[Y_W-1:0]   = y;
        fold          = '0;
        for (int w = 0; w < NWORDS; w++) begin
            fold = fold ^ yp[32*w +: 32];
        end
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ fold;
    endfunction

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dut_in_d = dut_in_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                // A new run reseeds everything; a start while busy never reaches here.
                if (bus.start) begin
                    state_d  = S_FETCH;
                    sig_d    = 32'hFFFF_FFFF;
                    cnt_d    = '0;
                    addr_d   = '0;
                    dut_in_d = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                dut_in_d = bus.vec_data;
                wait_d   = SETTLE_C;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 8'd1) begin
                    state_d = S_CAPT;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            S_CAPT: begin
                sig_d = misr_next(sig_q, bus.dut_y);
                cnt_d = cnt_inc;
                // Address stays on the last vector so it never exceeds NUM_VEC-1.
                if (cnt_inc == NUM_VEC_C) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status outputs are registered from the next state so they line up with it.
        busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d   = (state_d == S_DONE);
        vec_rd_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            vec_rd_q <= 1'b0;
            addr_q   <= '0;
            dut_in_q <= '0;
            sig_q    <= 32'hFFFF_FFFF;
            cnt_q    <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            vec_rd_q <= vec_rd_d;
            addr_q   <= addr_d;
            dut_in_q <= dut_in_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.vec_rd   = vec_rd_q;
    assign bus.vec_addr = addr_q;
    assign bus.dut_in   = dut_in_q;
    assign bus.sig      = sig_q;
    assign bus.vec_cnt  = cnt_q;

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Three sequencer instances with different run lengths/settle windows:
//   A: NUM_VEC=1,  SETTLE=1, y driven directly by the bench
//   B: NUM_VEC=3,  SETTLE=2, y = zero-extended dut_in (combinational stub)
//   C: NUM_VEC=21, SETTLE=1, y = registered passthrough of dut_in, random ROM
module tb_fuzz_vector_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fuzz_vector_sequencer_if #(.VEC_W(256), .Y_W(635), .ADDR_W(5)) ifa ();
    fuzz_vector_sequencer_if #(.VEC_W(256), .Y_W(635), .ADDR_W(5)) ifb ();
    fuzz_vector_sequencer_if #(.VEC_W(256), .Y_W(635), .ADDR_W(5)) ifc ();

    fuzz_vector_sequencer #(.VEC_W(256), .Y_W(635), .NUM_VEC(1), .ADDR_W(5), .SETTLE(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
    fuzz_vector_sequencer #(.VEC_W(256), .Y_W(635), .NUM_VEC(3), .ADDR_W(5), .SETTLE(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));
    fuzz_vector_sequencer #(.VEC_W(256), .Y_W(635), .NUM_VEC(21), .ADDR_W(5), .SETTLE(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.master));

    logic [255:0] rom_a [32];
    logic [255:0] rom_b [32];
    logic [255:0] rom_c [32];
    logic [634:0] y_a;

    // ROM models: data appears one cycle after the read strobe.
    always @(posedge clk) if (ifa.vec_rd) ifa.vec_data <= rom_a[ifa.vec_addr];
    always @(posedge clk) if (ifb.vec_rd) ifb.vec_data <= rom_b[ifb.vec_addr];
    always @(posedge clk) if (ifc.vec_rd) ifc.vec_data <= rom_c[ifc.vec_addr];

    // DUT stubs.
    assign ifa.dut_y = y_a;
    assign ifb.dut_y = {379'b0, ifb.dut_in};
    always @(posedge clk) ifc.dut_y <= {379'b0, ifc.dut_in};

    // Read-strobe log for instance B.
    int             rd_cyc[$];
    logic [4:0]     rd_addr[$];
    always @(posedge clk) begin
        if (ifb.vec_rd) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(ifb.vec_addr);
        end
    end

    // Reference model: signature = product of polynomial steps over the y seen per vector.
    function automatic logic [31:0] m_step(input logic [31:0] s, input logic [639:0] y);
        logic [32:0] sh;
        logic [31:0] fold;
        sh = {s, 1'b0};                       // multiply by x
        if (sh[32]) sh[31:0] = sh[31:0] ^ 32'h0040_0007;  // reduce mod x^32+x^22+x^2+x+1
        fold = 32'h0;
        for (int w = 0; w < 20; w++) fold = fold ^ y[w*32 +: 32];
        return sh[31:0] ^ fold;
    endfunction

    function automatic logic [639:0] yval(input int k, input int i);
        if (k == 0) return {5'b0, y_a};
        if (k == 1) return {384'b0, rom_b[i]};
        return {384'b0, rom_c[i]};
    endfunction

    function automatic logic [31:0] m_run(input int k, input int n);
        logic [31:0] s;
        s = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) s = m_step(s, yval(k, i));
        return s;
    endfunction

    function automatic logic busy_of(input int k);
        return (k == 0) ? ifa.busy : (k == 1) ? ifb.busy : ifc.busy;
    endfunction

    function automatic logic done_of(input int k);
        return (k == 0) ? ifa.done : (k == 1) ? ifb.done : ifc.done;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count busy cycles until done rises; a missing done is reported as a failure.
    task automatic wait_done(input int k, output int bcyc);
        bcyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (done_of(k)) break;
            if (busy_of(k)) bcyc++;
            tick();
        end
        chk($sformatf("done_reached_%0d", k), 256'(done_of(k)), 256'(1));
    endtask

    initial begin
        int          bc;
        logic [31:0] s1;
        int          fb;

        rst_n     = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        y_a       = '0;
        for (int i = 0; i < 32; i++) begin
            rom_a[i] = '0;
            rom_b[i] = 256'(i + 1);
            for (int w = 0; w < 8; w++) rom_c[i][w*32 +: 32] = $urandom;
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy",   256'(ifa.busy),     256'(0));
        chk("rst_done",   256'(ifa.done),     256'(0));
        chk("rst_vec_rd", 256'(ifa.vec_rd),   256'(0));
        chk("rst_addr",   256'(ifa.vec_addr), 256'(0));
        chk("rst_dut_in", ifa.dut_in,         256'(0));
        chk("rst_sig",    256'(ifa.sig),      256'(32'hFFFF_FFFF));
        chk("rst_cnt",    256'(ifa.vec_cnt),  256'(0));
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single-vector run, y=0
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        wait_done(0, bc);
        chk("a_busy_cycles", 256'(bc),          256'(4));
        chk("a_sig_y0",      256'(ifa.sig),     256'(32'hFFBF_FFF9));
        chk("a_cnt",         256'(ifa.vec_cnt), 256'(1));
        chk("a_addr",        256'(ifa.vec_addr), 256'(0));

        // Only bit 634 of y set: top fold word must reach the signature
        y_a = '0;
        y_a[634] = 1'b1;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("a_done_drop", 256'(ifa.done), 256'(0));
        wait_done(0, bc);
        chk("a_sig_y634",      256'(ifa.sig), 256'(32'hFBBF_FFF9));
        chk("a_sig_y634_model", 256'(ifa.sig), 256'(m_run(0, 1)));
        chk("a_sig_y634_diff", 256'(ifa.sig != 32'hFFBF_FFF9), 256'(1));

        // Three vectors, settle 2, start held high throughout
        rd_cyc.delete();
        rd_addr.delete();
        ifb.start = 1'b1;
        tick();
        wait_done(1, bc);
        chk("b_busy_cycles", 256'(bc),          256'(15));
        chk("b_cnt",         256'(ifb.vec_cnt), 256'(3));
        chk("b_sig",         256'(ifb.sig),     256'(m_run(1, 3)));
        chk("b_rd_count",    256'(rd_cyc.size()), 256'(3));
        if (rd_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("b_rd_addr%0d", i), 256'(rd_addr[i]), 256'(i));
            chk("b_rd_gap01", 256'(rd_cyc[1] - rd_cyc[0]), 256'(5));
            chk("b_rd_gap12", 256'(rd_cyc[2] - rd_cyc[1]), 256'(5));
        end
        chk("b_dut_in_last", ifb.dut_in, rom_b[2]);
        s1 = ifb.sig;
        tick();
        // Held start is accepted straight out of DONE
        chk("b_restart_done", 256'(ifb.done),    256'(0));
        chk("b_restart_busy", 256'(ifb.busy),    256'(1));
        chk("b_restart_sig",  256'(ifb.sig),     256'(32'hFFFF_FFFF));
        chk("b_restart_cnt",  256'(ifb.vec_cnt), 256'(0));
        ifb.start = 1'b0;
        wait_done(1, bc);
        chk("b_rerun_sig", 256'(ifb.sig), 256'(s1));

        // Asynchronous reset in the middle of a WAIT
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        repeat (10) tick();
        chk("c_midrun_busy", 256'(ifc.busy), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("c_arst_busy",   256'(ifc.busy),     256'(0));
        chk("c_arst_done",   256'(ifc.done),     256'(0));
        chk("c_arst_vec_rd", 256'(ifc.vec_rd),   256'(0));
        chk("c_arst_addr",   256'(ifc.vec_addr), 256'(0));
        chk("c_arst_dut_in", ifc.dut_in,         256'(0));
        chk("c_arst_sig",    256'(ifc.sig),      256'(32'hFFFF_FFFF));
        chk("c_arst_cnt",    256'(ifc.vec_cnt),  256'(0));
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Full 21-vector runs against random ROM contents
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        wait_done(2, bc);
        chk("c_busy_cycles", 256'(bc),           256'(84));
        chk("c_cnt",         256'(ifc.vec_cnt),  256'(21));
        chk("c_addr",        256'(ifc.vec_addr), 256'(20));
        chk("c_dut_in_last", ifc.dut_in,         rom_c[20]);
        chk("c_sig",         256'(ifc.sig),      256'(m_run(2, 21)));
        s1 = ifc.sig;

        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        wait_done(2, bc);
        chk("c_sig_repeat", 256'(ifc.sig), 256'(s1));

        fb = $urandom_range(255, 0);
        rom_c[20][fb] = ~rom_c[20][fb];
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        wait_done(2, bc);
        chk("c_sig_flip_diff",  256'(ifc.sig != s1), 256'(1));
        chk("c_sig_flip_model", 256'(ifc.sig),       256'(m_run(2, 21)));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
